// File: rtl/tb_sequencer.sv
// Run controller for the arithmetic testbench: clear, stimulate, drain, capture, with an optional fault phase.
// Optional stall watchdog is built when TB_SEQ_TIMEOUT_EN is defined.
module tb_sequencer #(
    parameter int unsigned CLEAR_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_dut,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_fault_en,
    input  logic [31:0] i_num_samples,
    input  logic [31:0] i_data_ctr,
    input  logic [31:0] i_error_ctr,
    output logic        o_tb_reset,
    output logic        o_tb_enable,
    output logic        o_tb_freeze,
    output logic        o_fselect,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [31:0] o_clean_errors,
    output logic [31:0] o_fault_errors,
    output logic [31:0] o_samples
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_CAPTURE, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] num_q, num_d;
    logic        fe_q, fe_d;
    logic        phase_q, phase_d;          // 0 = clean phase, 1 = fault phase
    logic [31:0] clean_q, clean_d;
    logic [31:0] fault_q, fault_d;
    logic [31:0] samples_q, samples_d;
    logic        pass_q, pass_d;
    logic        tmo_q, tmo_d;
    logic        reach_q;
    logic        tb_reset_q, enable_q, freeze_q, fsel_q, busy_q, done_q;
    logic        wd_fire;
    logic        abort_any;
    logic        in_run_states;

`ifdef TB_SEQ_TIMEOUT_EN
    logic [31:0] wd_q;
    logic [31:0] prev_ctr_q;

    // Watchdog restarts on any movement of the data counter while in RUN.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            wd_q       <= '0;
            prev_ctr_q <= '0;
        end else begin
            prev_ctr_q <= i_data_ctr;
            if (state_q != S_RUN || i_data_ctr != prev_ctr_q)
                wd_q <= '0;
            else
                wd_q <= wd_q + 32'd1;
        end
    end

    assign wd_fire = (state_q == S_RUN) && (wd_q >= 32'(TIMEOUT_CYCLES) - 32'd2);
`else
    assign wd_fire = 1'b0;
`endif

    assign abort_any     = i_abort || wd_fire;
    assign in_run_states = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                           (state_q == S_DRAIN) || (state_q == S_CAPTURE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        num_d     = num_q;
        fe_d      = fe_q;
        phase_d   = phase_q;
        clean_d   = clean_q;
        fault_d   = fault_q;
        samples_d = samples_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    state_d = S_CLEAR;
                    num_d   = i_num_samples;
                    fe_d    = i_fault_en;
                    phase_d = 1'b0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    if (!i_fault_en) fault_d = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == 32'(CLEAR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (num_q == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (reach_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cnt_d     = '0;
                samples_d = i_data_ctr;
                if (phase_q) fault_d = i_error_ctr;
                else         clean_d = i_error_ctr;
                if (!phase_q && fe_q) begin
                    phase_d = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_DONE;
                    pass_d  = (clean_d == '0) && (!fe_q || (fault_d != '0));
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Abort discards anything captured this cycle and forces a failing verdict.
        if (abort_any && in_run_states) begin
            state_d   = S_DONE;
            cnt_d     = '0;
            phase_d   = phase_q;
            clean_d   = clean_q;
            fault_d   = fault_q;
            samples_d = samples_q;
            pass_d    = 1'b0;
            if (wd_fire) tmo_d = 1'b1;
        end
    end

    // Outputs are decoded from next state so every one of them is a flop.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            fe_q       <= 1'b0;
            phase_q    <= 1'b0;
            clean_q    <= '0;
            fault_q    <= '0;
            samples_q  <= '0;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
            reach_q    <= 1'b0;
            tb_reset_q <= 1'b0;
            enable_q   <= 1'b0;
            freeze_q   <= 1'b0;
            fsel_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            fe_q       <= fe_d;
            phase_q    <= phase_d;
            clean_q    <= clean_d;
            fault_q    <= fault_d;
            samples_q  <= samples_d;
            pass_q     <= pass_d;
            tmo_q      <= tmo_d;
            reach_q    <= (state_q == S_RUN) && (i_data_ctr >= num_q);
            tb_reset_q <= (state_d == S_CLEAR);
            enable_q   <= (state_d == S_RUN);
            freeze_q   <= (state_d == S_CAPTURE);
            fsel_q     <= phase_d && ((state_d == S_CLEAR) || (state_d == S_RUN) ||
                                      (state_d == S_DRAIN) || (state_d == S_CAPTURE));
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign o_tb_reset     = tb_reset_q;
    assign o_tb_enable    = enable_q;
    assign o_tb_freeze    = freeze_q;
    assign o_fselect      = fsel_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_pass         = pass_q;
    assign o_timeout      = tmo_q;
    assign o_clean_errors = clean_q;
    assign o_fault_errors = fault_q;
    assign o_samples      = samples_q;

endmodule

// File: tb/tb_tb_sequencer.sv
// Directed bench for tb_sequencer: a stand-in data/error counter environment plus a result scoreboard.
module tb_tb_sequencer;

    localparam int CLR = 2;
    localparam int SET = 4;

    logic        clk_dut = 1'b0;
    logic        reset;
    logic        i_start, i_abort, i_fault_en;
    logic [31:0] i_num_samples, i_data_ctr, i_error_ctr;
    logic        o_tb_reset, o_tb_enable, o_tb_freeze, o_fselect;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [31:0] o_clean_errors, o_fault_errors, o_samples;

    tb_sequencer #(.CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(1024)) dut (
        .clk_dut(clk_dut), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_fault_en(i_fault_en), .i_num_samples(i_num_samples), .i_data_ctr(i_data_ctr),
        .i_error_ctr(i_error_ctr), .o_tb_reset(o_tb_reset), .o_tb_enable(o_tb_enable),
        .o_tb_freeze(o_tb_freeze), .o_fselect(o_fselect), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_timeout(o_timeout), .o_clean_errors(o_clean_errors),
        .o_fault_errors(o_fault_errors), .o_samples(o_samples)
    );

    initial forever #5 clk_dut = ~clk_dut;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [31:0] clean;
        logic [31:0] fault;
        logic [31:0] samples;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   done_cnt, en_cnt, fsel_cnt, fsel_early, rst_rise, rst_hi, frz_cnt;
    logic prev_rst = 1'b0;
    logic [31:0] env_n = 0, env_cv = 0, env_fv = 0;
    logic [31:0] prev_clean = 0, prev_fault = 0, prev_samples = 0;

    // Environment: counters clear under tb reset; the source emits exactly env_n samples.
    initial begin
        i_data_ctr  = '0;
        i_error_ctr = '0;
        forever begin
            @(negedge clk_dut);
            if (o_tb_reset && !prev_rst) rst_rise++;
            if (o_tb_reset) rst_hi++;
            prev_rst = o_tb_reset;
            if (o_done) done_cnt++;
            if (o_tb_enable) en_cnt++;
            if (o_tb_freeze) frz_cnt++;
            if (o_fselect) begin
                fsel_cnt++;
                if (rst_rise < 2) fsel_early++;
            end
            if (o_tb_reset) begin
                i_data_ctr  = '0;
                i_error_ctr = '0;
            end else if (o_tb_enable) begin
                if (i_data_ctr < env_n) i_data_ctr = i_data_ctr + 32'd1;
                i_error_ctr = o_fselect ? env_fv : env_cv;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk_dut);
        done_cnt = 0; en_cnt = 0; fsel_cnt = 0; fsel_early = 0;
        rst_rise = 0; rst_hi = 0; frz_cnt = 0;
    endtask

    task automatic score(input int lat, input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_done"},    o_done,         1);
        chk({tag, "_busy"},    o_busy,         1);
        chk({tag, "_pass"},    o_pass,         e.pass);
        chk({tag, "_timeout"}, o_timeout,      e.tmo);
        chk({tag, "_clean"},   o_clean_errors, e.clean);
        chk({tag, "_fault"},   o_fault_errors, e.fault);
        chk({tag, "_samples"}, o_samples,      e.samples);
        chk({tag, "_latency"}, lat,            e.lat);
        prev_clean   = e.clean;
        prev_fault   = e.fault;
        prev_samples = e.samples;
    endtask

    task automatic run(input logic [31:0] n, input logic fe, input logic [31:0] cv,
                       input logic [31:0] fv, input logic ab, input int busy_at, input string tag);
        exp_t e;
        int   ph_len, phases, cnt;
        phases    = fe ? 2 : 1;
        ph_len    = CLR + ((n == 0) ? 0 : int'(n) + 1) + SET + 1;
        e.clean   = (n == 0) ? 32'd0 : cv;
        e.fault   = (fe && n != 0) ? fv : 32'd0;
        e.samples = n;
        e.pass    = (e.clean == 0) && (!fe || e.fault != 0);
        e.tmo     = 1'b0;
        e.lat     = phases * ph_len + 1;
        sb.push_back(e);
        env_n = n; env_cv = cv; env_fv = fv;
        i_num_samples = n;
        i_fault_en    = fe;
        clr_mon();
        @(negedge clk_dut);
        i_start = 1'b1;
        i_abort = ab;
        cnt = 0;
        do begin
            @(negedge clk_dut);
            cnt++;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (cnt == busy_at) i_start = 1'b1;
        end while (!o_done && cnt < 5000);
        score(cnt, tag);
        repeat (3) @(negedge clk_dut);
        chk({tag, "_done_once"}, done_cnt,  1);
        chk({tag, "_idle"},      o_busy,    0);
        chk({tag, "_rst_rise"},  rst_rise,  phases);
        chk({tag, "_rst_len"},   rst_hi,    phases * CLR);
        chk({tag, "_freeze"},    frz_cnt,   phases);
        chk({tag, "_enable"},    en_cnt,    phases * ((n == 0) ? 0 : int'(n) + 1));
        chk({tag, "_fsel"},      fsel_cnt,  fe ? ph_len : 0);
        chk({tag, "_fsel_early"}, fsel_early, 0);
    endtask

    initial begin
        exp_t e;
        int   cnt;
        reset = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_fault_en = 1'b0; i_num_samples = '0;
        repeat (3) @(negedge clk_dut);
        chk("rst_busy",   o_busy,         0);
        chk("rst_done",   o_done,         0);
        chk("rst_tbrst",  o_tb_reset,     0);
        chk("rst_enable", o_tb_enable,    0);
        chk("rst_pass",   o_pass,         0);
        chk("rst_samples", o_samples,     0);
        reset = 1'b1;
        repeat (2) @(negedge clk_dut);

        run(100, 1'b0, 0, 0, 1'b0, 50, "clean100");
        run(50,  1'b1, 0, 7, 1'b0, 0,  "fault50");

        // Abort in the clean phase RUN of a fault run: earlier results must survive.
        e.pass = 1'b0; e.tmo = 1'b0; e.clean = prev_clean; e.fault = prev_fault;
        e.samples = prev_samples; e.lat = 21;
        sb.push_back(e);
        env_n = 100; env_cv = 0; env_fv = 5;
        i_num_samples = 100; i_fault_en = 1'b1;
        clr_mon();
        @(negedge clk_dut);
        i_start = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk_dut);
            cnt++;
            i_start = 1'b0;
        end
        chk("abort_in_run", o_tb_enable, 1);
        i_abort = 1'b1;
        @(negedge clk_dut);
        cnt++;
        i_abort = 1'b0;
        score(cnt, "abort");
        repeat (3) @(negedge clk_dut);
        chk("abort_done_once", done_cnt, 1);
        chk("abort_idle",      o_busy,   0);

        run(20, 1'b0, 3, 0, 1'b0, 0, "clean_err");

        // Asynchronous reset in the middle of CLEAR.
        i_num_samples = 100; i_fault_en = 1'b0; env_n = 100; env_cv = 0;
        @(negedge clk_dut);
        i_start = 1'b1;
        @(negedge clk_dut);
        i_start = 1'b0;
        chk("pre_rst_clear", o_tb_reset, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",   o_busy,         0);
        chk("arst_tbrst",  o_tb_reset,     0);
        chk("arst_clean",  o_clean_errors, 0);
        chk("arst_samples", o_samples,     0);
        chk("arst_done",   o_done,         0);
        @(negedge clk_dut);
        reset = 1'b1;
        repeat (4) @(negedge clk_dut);
        chk("arst_idle",   o_busy,      0);
        chk("arst_no_en",  o_tb_enable, 0);
        prev_clean = 0; prev_fault = 0; prev_samples = 0;

        run(30, 1'b1, 0, 0, 1'b1, 0, "fault_miss");
        run(0,  1'b0, 0, 0, 1'b0, 0, "zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
